// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: receives PS/2 keyboard frames and decodes scan-code sequences.
//   Clock, Reset      : system clock, asynchronous active-high reset
//   iPS2_CLK/iPS2_DATA: raw keyboard clock/data, asynchronous to Clock
//   oKeyCode          : final (non-prefix) byte of a key sequence, held until next oKeyValid
//   oRelease          : F0 prefix preceded oKeyCode
//   oExtended         : E0 prefix preceded oKeyCode
//   oKeyValid         : one-cycle strobe qualifying oKeyCode/oRelease/oExtended
//   oParityError      : one-cycle strobe, frame failed parity or stop-bit check
//   oFrameError       : one-cycle strobe, frame aborted by inter-bit timeout
module ps2_frame_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DATA,
  output logic [7:0] oKeyCode,
  output logic       oRelease,
  output logic       oExtended,
  output logic       oKeyValid,
  output logic       oParityError,
  output logic       oFrameError
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Synchronizers
  logic clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;

  // Glitch filter
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           sample_c;

  // Frame FSM and datapath
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           rel_flag_q, rel_flag_d;
  logic           ext_flag_q, ext_flag_d;

  // Registered outputs
  logic [7:0] key_code_q, key_code_d;
  logic       release_q, release_d;
  logic       extended_q, extended_d;
  logic       key_valid_q, key_valid_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;

  // Two-flop synchronizers, idle-high
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= iPS2_CLK;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= iPS2_DATA;
      data_s2_q <= data_s1_q;
    end
  end

  // Filtered clock flips after FILTER_LEN consecutive samples at the opposite level
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  // Sample event: the cycle in which the filtered clock commits a 1->0 change
  assign sample_c = filt_q & ~filt_d;

  // Next-state, datapath and output logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    rel_flag_d  = rel_flag_q;
    ext_flag_d  = ext_flag_q;
    key_code_d  = key_code_q;
    release_d   = release_q;
    extended_d  = extended_q;
    key_valid_d = 1'b0;
    par_err_d   = 1'b0;
    frm_err_d   = 1'b0;
    tmo_d       = (state_q == IDLE) ? '0 : tmo_q + TCW'(1);

    if (sample_c) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = data_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          if (data_s2_q && (^{shift_q, par_q})) begin
            if (shift_q == 8'hF0) begin
              rel_flag_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_flag_d = 1'b1;
            end else begin
              key_code_d  = shift_q;
              release_d   = rel_flag_q;
              extended_d  = ext_flag_q;
              key_valid_d = 1'b1;
              rel_flag_d  = 1'b0;
              ext_flag_d  = 1'b0;
            end
          end else begin
            par_err_d  = 1'b1;
            rel_flag_d = 1'b0;
            ext_flag_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && (tmo_q == TCW'(TIMEOUT_CYCLES - 1))) begin
      // Keyboard went silent mid-frame: abandon it
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      tmo_d      = '0;
      frm_err_d  = 1'b1;
      rel_flag_d = 1'b0;
      ext_flag_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      rel_flag_q  <= 1'b0;
      ext_flag_q  <= 1'b0;
      key_code_q  <= '0;
      release_q   <= 1'b0;
      extended_q  <= 1'b0;
      key_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      rel_flag_q  <= rel_flag_d;
      ext_flag_q  <= ext_flag_d;
      key_code_q  <= key_code_d;
      release_q   <= release_d;
      extended_q  <= extended_d;
      key_valid_q <= key_valid_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
    end
  end

  assign oKeyCode     = key_code_q;
  assign oRelease     = release_q;
  assign oExtended    = extended_q;
  assign oKeyValid    = key_valid_q;
  assign oParityError = par_err_q;
  assign oFrameError  = frm_err_q;

endmodule
